// File: rtl/core_pkg.sv
// Shared register-index definitions for the core pipeline blocks.
// Contents:
//   REG_IDX_W  width of an architectural register index
//   NUM_REGS   number of architectural registers (RV32E)
//   reg_idx_t  register index type
//   REG_ZERO   index of the hard-wired zero register
package core_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned NUM_REGS  = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 4'd0;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// sb_counter: one saturating up/down pending-write counter.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (clears the count)
//   inc      in   add one this cycle
//   dec_a    in   subtract one this cycle (retire)
//   dec_b    in   subtract one this cycle (kill)
//   nonzero  out  count != 0
//   is_one   out  count == 1
//   is_max   out  count == 2^CNT_W-1
//   err      out  this cycle's update would under/overflow (count saturates)
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec_a,
    input  logic dec_b,
    output logic nonzero,
    output logic is_one,
    output logic is_max,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W+1:0] up;
    logic [CNT_W+1:0] down;
    logic [CNT_W+1:0] diff;

    // Inc and both decrements are summed so they can cancel in one cycle.
    always_comb begin
        cnt_next = cnt;
        err      = 1'b0;
        up       = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, inc};
        down     = {{(CNT_W+1){1'b0}}, dec_a} + {{(CNT_W+1){1'b0}}, dec_b};
        diff     = '0;
        if (up < down) begin
            cnt_next = '0;
            err      = 1'b1;
        end else begin
            diff = up - down;
            if (diff > {2'b00, CNT_MAX}) begin
                cnt_next = CNT_MAX;
                err      = 1'b1;
            end else begin
                cnt_next = diff[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    assign nonzero = (cnt != '0);
    assign is_one  = (cnt == {{(CNT_W-1){1'b0}}, 1'b1});
    assign is_max  = (cnt == CNT_MAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: tracks register writes in flight between issue and
// writeback, and produces RAW / capacity stalls for the decode stage.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid/we/rd          instruction leaving decode and its destination
//   dec_rs1/rs2, dec_use_*     sources of the instruction sitting in decode
//   wb_valid/wb_rd             a tracked write retires this cycle
//   kill_valid/kill_rd         a tracked write is squashed this cycle
//   raw_stall                  decode must hold for a pending source (comb)
//   full_stall                 issue blocked by counter/in-flight limit (comb)
//   pending_mask               bit r set while register r has pending writes
//   inflight                   total pending writes
//   err                        sticky under/overflow flag
module regfile_scoreboard #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned CNT_W        = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_we,
    input  logic [3:0]          issue_rd,
    input  logic [3:0]          dec_rs1,
    input  logic [3:0]          dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic                wb_valid,
    input  logic [3:0]          wb_rd,
    input  logic                kill_valid,
    input  logic [3:0]          kill_rd,
    output logic                raw_stall,
    output logic                full_stall,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [2:0]          inflight,
    output logic                err
);

    import core_pkg::reg_idx_t;
    import core_pkg::REG_ZERO;

    logic                issue_cand;
    logic                tracked_issue;
    logic                wb_dec;
    logic                kill_dec;
    logic                issue_match;
    logic                rs1_hit;
    logic                rs2_hit;
    logic [NUM_REGS-1:0] nonzero_v;
    logic [NUM_REGS-1:0] is_one_v;
    logic [NUM_REGS-1:0] is_max_v;
    logic [NUM_REGS-1:0] cnt_err_v;
    logic [3:0]          infl_up;
    logic [3:0]          infl_down;
    logic [3:0]          infl_diff;
    logic [2:0]          inflight_next;
    logic                infl_err;

    // x0 is never tracked: no counter, and retire/kill of x0 are ignored.
    assign nonzero_v[0] = 1'b0;
    assign is_one_v[0]  = 1'b0;
    assign is_max_v[0]  = 1'b0;
    assign cnt_err_v[0] = 1'b0;

    assign wb_dec     = wb_valid & (wb_rd != REG_ZERO);
    assign kill_dec   = kill_valid & (kill_rd != REG_ZERO);
    assign issue_cand = issue_we & (issue_rd != REG_ZERO);

    // A same-cycle retire/kill of the issuing rd nets the counter to zero
    // change, so the limit does not block that issue.
    assign issue_match = (wb_dec & (wb_rd == issue_rd)) |
                         (kill_dec & (kill_rd == issue_rd));

    assign full_stall = issue_cand &
                        (is_max_v[issue_rd] | (inflight == 3'(MAX_INFLIGHT))) &
                        !issue_match;

    assign tracked_issue = issue_valid & issue_cand & !full_stall;

    // Retiring the last pending write bypasses via regfile write-through;
    // a kill does not, since no data is produced.
    assign rs1_hit = dec_use_rs1 & (dec_rs1 != REG_ZERO) & nonzero_v[dec_rs1] &
                     !(wb_valid & (wb_rd == dec_rs1) & is_one_v[dec_rs1]);
    assign rs2_hit = dec_use_rs2 & (dec_rs2 != REG_ZERO) & nonzero_v[dec_rs2] &
                     !(wb_valid & (wb_rd == dec_rs2) & is_one_v[dec_rs2]);
    assign raw_stall = rs1_hit | rs2_hit;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (tracked_issue & (issue_rd == reg_idx_t'(g))),
            .dec_a   (wb_dec & (wb_rd == reg_idx_t'(g))),
            .dec_b   (kill_dec & (kill_rd == reg_idx_t'(g))),
            .nonzero (nonzero_v[g]),
            .is_one  (is_one_v[g]),
            .is_max  (is_max_v[g]),
            .err     (cnt_err_v[g])
        );
    end

    // Counters are registered, so the mask is a direct view of flop state.
    assign pending_mask = nonzero_v;

    always_comb begin
        inflight_next = inflight;
        infl_err      = 1'b0;
        infl_up       = {1'b0, inflight} + {3'b000, tracked_issue};
        infl_down     = {3'b000, wb_dec} + {3'b000, kill_dec};
        infl_diff     = '0;
        if (infl_up < infl_down) begin
            inflight_next = '0;
            infl_err      = 1'b1;
        end else begin
            infl_diff = infl_up - infl_down;
            if (infl_diff > 4'(MAX_INFLIGHT)) begin
                inflight_next = 3'(MAX_INFLIGHT);
                infl_err      = 1'b1;
            end else begin
                inflight_next = infl_diff[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight_next;
            err      <= err | infl_err | (|cnt_err_v);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_we;
    logic [3:0]  issue_rd;
    logic [3:0]  dec_rs1;
    logic [3:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        kill_valid;
    logic [3:0]  kill_rd;
    logic        raw_stall;
    logic        full_stall;
    logic [15:0] pending_mask;
    logic [2:0]  inflight;
    logic        err;

    int checks;
    int failures;

    regfile_scoreboard #(
        .NUM_REGS     (16),
        .CNT_W        (2),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_use_rs1  (dec_use_rs1),
        .dec_use_rs2  (dec_use_rs2),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .kill_valid   (kill_valid),
        .kill_rd      (kill_rd),
        .raw_stall    (raw_stall),
        .full_stall   (full_stall),
        .pending_mask (pending_mask),
        .inflight     (inflight),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit after that, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 4'd0;
        dec_rs1 = 4'd0; dec_rs2 = 4'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        wb_valid = 1'b0; wb_rd = 4'd0; kill_valid = 1'b0; kill_rd = 4'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic [3:0] rd);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
        tick();
        issue_valid = 1'b0; issue_we = 1'b0; issue_rd = 4'd0;
    endtask

    task automatic retire(input logic [3:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
        tick();
        wb_valid = 1'b0; wb_rd = 4'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd5;
        tick();
        checks++;
        if (pending_mask !== 16'h0000) begin
            failures++; $display("FAIL reset_mask got=%h exp=%h", pending_mask, 16'h0000);
        end
        checks++;
        if (inflight !== 3'd0) begin
            failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", err);
        end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_raw();
        do_reset();
        issue(4'd3);
        dec_rs1 = 4'd3; dec_use_rs1 = 1'b1;
        #1;
        checks++;
        if (raw_stall !== 1'b1) begin
            failures++; $display("FAIL raw_stall_set got=%b exp=1", raw_stall);
        end
        checks++;
        if (pending_mask !== 16'h0008) begin
            failures++; $display("FAIL raw_mask got=%h exp=0008", pending_mask);
        end
        tick();
        checks++;
        if (raw_stall !== 1'b1) begin
            failures++; $display("FAIL raw_stall_hold got=%b exp=1", raw_stall);
        end
        wb_valid = 1'b1; wb_rd = 4'd3;
        #1;
        checks++;
        if (raw_stall !== 1'b0) begin
            failures++; $display("FAIL raw_wb_bypass got=%b exp=0", raw_stall);
        end
        tick();
        wb_valid = 1'b0; wb_rd = 4'd0;
        #1;
        checks++;
        if (pending_mask !== 16'h0000 || inflight !== 3'd0 || raw_stall !== 1'b0) begin
            failures++;
            $display("FAIL raw_cleared got mask=%h infl=%0d stall=%b exp mask=0000 infl=0 stall=0",
                     pending_mask, inflight, raw_stall);
        end
        clear_inputs();
    endtask

    task automatic test_x0();
        do_reset();
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd0;
        dec_rs1 = 4'd0; dec_use_rs1 = 1'b1;
        #1;
        checks++;
        if (raw_stall !== 1'b0 || full_stall !== 1'b0) begin
            failures++; $display("FAIL x0_stalls got raw=%b full=%b exp raw=0 full=0", raw_stall, full_stall);
        end
        tick();
        checks++;
        if (inflight !== 3'd0 || pending_mask !== 16'h0000) begin
            failures++; $display("FAIL x0_untracked got infl=%0d mask=%h exp infl=0 mask=0000", inflight, pending_mask);
        end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        issue(4'd7);
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd7;
        wb_valid = 1'b1; wb_rd = 4'd7;
        dec_rs2 = 4'd7; dec_use_rs2 = 1'b1;
        #1;
        checks++;
        if (full_stall !== 1'b0) begin
            failures++; $display("FAIL simul_full got=%b exp=0", full_stall);
        end
        checks++;
        if (raw_stall !== 1'b0) begin
            failures++; $display("FAIL simul_raw_bypass got=%b exp=0", raw_stall);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (pending_mask !== 16'h0080 || inflight !== 3'd1) begin
            failures++; $display("FAIL simul_state got mask=%h infl=%0d exp mask=0080 infl=1", pending_mask, inflight);
        end
        retire(4'd7);
        checks++;
        if (pending_mask !== 16'h0000 || inflight !== 3'd0 || err !== 1'b0) begin
            failures++; $display("FAIL simul_drain got mask=%h infl=%0d err=%b exp 0000/0/0", pending_mask, inflight, err);
        end
    endtask

    task automatic test_kill();
        do_reset();
        issue(4'd9);
        kill_valid = 1'b1; kill_rd = 4'd9;
        dec_rs2 = 4'd9; dec_use_rs2 = 1'b1;
        #1;
        checks++;
        if (raw_stall !== 1'b1) begin
            failures++; $display("FAIL kill_no_bypass got=%b exp=1", raw_stall);
        end
        tick();
        kill_valid = 1'b0; kill_rd = 4'd0;
        #1;
        checks++;
        if (raw_stall !== 1'b0) begin
            failures++; $display("FAIL kill_stall_clear got=%b exp=0", raw_stall);
        end
        checks++;
        if (inflight !== 3'd0 || pending_mask !== 16'h0000) begin
            failures++; $display("FAIL kill_state got infl=%0d mask=%h exp infl=0 mask=0000", inflight, pending_mask);
        end
        clear_inputs();
    endtask

    task automatic test_counter_max();
        do_reset();
        for (int i = 0; i < 3; i++) issue(4'd5);
        checks++;
        if (inflight !== 3'd3 || pending_mask !== 16'h0020) begin
            failures++; $display("FAIL cmax_fill got infl=%0d mask=%h exp infl=3 mask=0020", inflight, pending_mask);
        end
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd5;
        #1;
        checks++;
        if (full_stall !== 1'b1) begin
            failures++; $display("FAIL cmax_full got=%b exp=1", full_stall);
        end
        wb_valid = 1'b1; wb_rd = 4'd5;
        #1;
        checks++;
        if (full_stall !== 1'b0) begin
            failures++; $display("FAIL cmax_full_wb got=%b exp=0", full_stall);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (inflight !== 3'd3 || err !== 1'b0) begin
            failures++; $display("FAIL cmax_net got infl=%0d err=%b exp infl=3 err=0", inflight, err);
        end
        for (int i = 0; i < 3; i++) retire(4'd5);
        checks++;
        if (inflight !== 3'd0 || pending_mask !== 16'h0000 || err !== 1'b0) begin
            failures++; $display("FAIL cmax_drain got infl=%0d mask=%h err=%b exp 0/0000/0", inflight, pending_mask, err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(4'd10);
        issue(4'd10);
        wb_valid = 1'b1; wb_rd = 4'd10;
        kill_valid = 1'b1; kill_rd = 4'd10;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (inflight !== 3'd0 || pending_mask !== 16'h0000 || err !== 1'b0) begin
            failures++; $display("FAIL double_dec got infl=%0d mask=%h err=%b exp 0/0000/0", inflight, pending_mask, err);
        end
    endtask

    task automatic test_limits();
        do_reset();
        issue(4'd1);
        issue(4'd2);
        issue(4'd4);
        issue(4'd6);
        checks++;
        if (inflight !== 3'd4 || pending_mask !== 16'h0056) begin
            failures++; $display("FAIL lim_fill got infl=%0d mask=%h exp infl=4 mask=0056", inflight, pending_mask);
        end
        issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd8;
        #1;
        checks++;
        if (full_stall !== 1'b1) begin
            failures++; $display("FAIL lim_full got=%b exp=1", full_stall);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (inflight !== 3'd4 || pending_mask !== 16'h0056 || err !== 1'b0) begin
            failures++; $display("FAIL lim_blocked got infl=%0d mask=%h err=%b exp 4/0056/0", inflight, pending_mask, err);
        end
        retire(4'd1);
        retire(4'd2);
        retire(4'd4);
        retire(4'd6);
        checks++;
        if (inflight !== 3'd0 || err !== 1'b0) begin
            failures++; $display("FAIL lim_drain got infl=%0d err=%b exp 0/0", inflight, err);
        end
        retire(4'd1);
        checks++;
        if (err !== 1'b1 || inflight !== 3'd0 || pending_mask !== 16'h0000) begin
            failures++; $display("FAIL underflow got err=%b infl=%0d mask=%h exp 1/0/0000", err, inflight, pending_mask);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_sticky got=%b exp=1", err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL err_reset got=%b exp=0", err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_raw();
        test_x0();
        test_simultaneous();
        test_kill();
        test_counter_max();
        test_back_to_back();
        test_limits();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Tracks register writes that are issued into the EX→MEMPREP→MEM→WB pipeline but have not yet retired. Sits beside decode: the pipeline registers carry rd/regfile_we forward toward writeback, and this block sees the consumer side of those fields. It reports which architectural registers are pending and raises a read-after-write stall for the instruction in decode. Retire and kill notifications from the downstream stages decrement per-register pending counters.

Parameters:
NUM_REGS, 16, architectural registers (RV32E); x0 is never tracked.
CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2^CNT_W-1.
MAX_INFLIGHT, 4, max total pending writes; equals the number of stages between issue and writeback.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
issue_valid  in  1  decode instruction advances into EX this cycle (already qualified by !stall).
issue_we  in  1  issuing instruction writes rd.
issue_rd  in  4  destination of the issuing instruction.
dec_rs1, dec_rs2  in  4 each  sources of the instruction in decode.
dec_use_rs1, dec_use_rs2  in  1 each  decode instruction actually reads rs1 / rs2.
wb_valid  in  1  a tracked write retires (regfile written) this cycle.
wb_rd  in  4  register retired.
kill_valid  in  1  a tracked write is squashed (invalid_EX path) this cycle.
kill_rd  in  4  register of the squashed write.
raw_stall  out  1  decode must hold (combinational).
full_stall  out  1  issue is blocked by a counter or in-flight limit (combinational).
pending_mask  out  16  registered; bit r = counter[r] != 0; bit 0 is always 0.
inflight  out  3  registered; total pending writes, 0..MAX_INFLIGHT.
err  out  1  sticky; set on a decrement of a zero counter or an increment past a limit.

Behaviour:
- Reset (rst_n=0 at posedge): all counters 0, pending_mask=0, inflight=0, err=0. Reset takes priority over all inputs. Reset mid-stream discards all pending state.
- An issue is tracked only when issue_valid & issue_we & issue_rd!=0. Retire, kill, and the rs1/rs2 checks ignore register 0.
- Per-register next counter = cnt + inc − dec_wb − dec_kill, where each term is 0 or 1. Issue, retire and kill hitting the same rd in one cycle are summed, so issue+retire leaves the counter unchanged. wb_rd==kill_rd with both valid decrements by 2.
- inflight_next = inflight + tracked_issue − wb_valid − kill_valid.
- raw_stall = (dec_use_rs1 & rs1!=0 & cnt[rs1]!=0 & !(wb_valid & wb_rd==rs1 & cnt[rs1]==1)) OR the same term for rs2. A retire in the same cycle bypasses the stall: the regfile forwards the write-through.
- A kill of the only pending write does NOT bypass the stall. The stall clears on the next cycle.
- full_stall = issue_we & issue_rd!=0 & (cnt[issue_rd]==2^CNT_W−1 OR inflight==MAX_INFLIGHT) & !(matching wb/kill this cycle). The pipeline ORs full_stall into stall. A blocked issue is not counted, even if issue_valid is asserted.
- Underflow (decrement of a 0 counter) or overflow: counter and inflight saturate, and err is set until reset.
- Latency: issue at edge N makes pending_mask visible at N+1. raw_stall is combinational from registered counters and wb inputs.

Decomposition:
- Shared package (core_pkg): REG_IDX_W=4, NUM_REGS=16, typedef reg_idx_t logic[3:0], constant REG_ZERO=4'd0.
- One sub-module, sb_counter: a single saturating up/down counter with inc, dec_a, dec_b, and outputs nonzero/is_one/is_max/err. Instantiate it 15 times in a generate loop (registers 1..15).

Test Plan:
- Reset: drive issue_valid/we rd=5 while rst_n=0 → pending_mask=0, inflight=0, err=0 after the edge.
- RAW: issue rd=3 at N; decode rs1=3 use=1 → raw_stall=1 at N+1. wb rd=3 at N+3 → raw_stall=0 in that same cycle; pending_mask[3]=0 at N+4.
- x0: issue rd=0, decode rs1=0 → inflight stays 0, raw_stall=0, pending_mask=0.
- Simultaneous: cnt[7]=1, issue rd=7 and wb rd=7 in one cycle → cnt[7] stays 1, inflight unchanged, full_stall=0.
- Kill: issue rd=9, then kill rd=9 with decode rs2=9 → raw_stall=1 that cycle, 0 next; inflight back to 0.
- Limits: 4 tracked issues to distinct rd → inflight=4; 5th issue → full_stall=1, not counted. Extra wb with all counters 0 → err=1, sticky until rst_n=0.
